ddr3_wb_arbiter: RTL
====================

// Module: ddr3_wb_arbiter
// PURPOSE
//  N-port pipelined Wishbone front end for the DDR3 controller user port. Round-robin
//  arbitrates N masters onto one Wishbone stream and tags each request with its port
//  ID in the controller aux field. Routes each returned ack/data/aux to the tagged
//  port. Supports per-port bus abort without aborting the shared downstream bus.
// PARAMETERS
//  NUM_PORTS        4    number of upstream masters (2..8)
//  WB_ADDR_BITS     24   burst address width (matches controller wb_addr_bits)
//  WB_DATA_BITS     512  data width (matches controller wb_data_bits)
//  PORT_AUX_WIDTH   8    per-port aux; downstream aux = {tag, port aux}
//  TAG_BITS         $clog2(NUM_PORTS) (derived)
//  MAX_OUTSTANDING  16   per-port in-flight request cap (power of 2)
// PORTS
//  i_controller_clk  in   1                      controller clock
//  i_rst             in   1                      synchronous active-high reset
//  i_port_cyc/stb/we in   NUM_PORTS each         per-port Wishbone controls
//  i_port_addr       in   NUM_PORTS*WB_ADDR_BITS packed, port p at [p*W +: W]
//  i_port_data       in   NUM_PORTS*WB_DATA_BITS packed write data
//  i_port_sel        in   NUM_PORTS*WB_DATA_BITS/8 packed byte strobes
//  i_port_aux        in   NUM_PORTS*PORT_AUX_WIDTH packed aux
//  o_port_stall      out  NUM_PORTS              1 = port request not accepted
//  o_port_ack        out  NUM_PORTS              one-hot completion
//  o_port_data       out  WB_DATA_BITS           read data, shared, qualified by ack
//  o_port_aux        out  PORT_AUX_WIDTH         returned aux, shared, qualified by ack
//  o_wb_cyc/stb/we   out  1 each                 to controller
//  o_wb_addr/data/sel out WB_ADDR_BITS/WB_DATA_BITS/WB_DATA_BITS/8
//  o_wb_aux          out  TAG_BITS+PORT_AUX_WIDTH {tag, port aux}
//  i_wb_stall,i_wb_ack in 1 each                 from controller
//  i_wb_data         in   WB_DATA_BITS           read data from controller
//  i_wb_aux          in   TAG_BITS+PORT_AUX_WIDTH aux returned with ack
// BEHAVIOUR
//  - Reset: rr pointer=0; all pending[p] and discard[p] = 0; o_wb_cyc=0; o_port_ack=0.
//    o_port_stall=all 1s during reset cycle.
//  - Eligible port p: i_port_cyc[p] & i_port_stb[p] & discard[p]==0
//    & pending[p]<MAX_OUTSTANDING.
//  - Grant (combinational): first eligible port at or after rr pointer, wrapping
//    modulo NUM_PORTS.
//  - o_wb_stb = any eligible; request fields muxed from the granted port;
//    o_wb_aux = {grant idx, port aux}.
//  - o_port_stall[p] = ~(granted==p & eligible) | i_wb_stall.
//  - Accept = o_wb_stb & ~i_wb_stall. On accept: pending[grant]++, rr pointer <= grant+1 (wrap).
//    Zero added request latency.
//  - o_wb_cyc = any i_port_cyc | any pending!=0 | any discard!=0. Downstream cyc never
//    drops with requests in flight.
//  - Ack routing (registered, 1 cycle): on i_wb_ack, t = i_wb_aux tag.
//    If discard[t]!=0: discard[t]--, no ack. Else: pending[t]--, o_port_ack[t]=1,
//    o_port_data/aux registered.
//  - Abort: port p with i_port_cyc[p]=0 and pending[p]!=0 -> discard[p] += pending[p]
//    (minus any ack consumed same cycle), pending[p]=0.
//    Port p is ineligible until discard[p]==0.
//  - Simultaneous accept and ack on same port: pending unchanged.
//    Counter width $clog2(MAX_OUTSTANDING)+1; never over- or underflows.
//  - Ack with tag >= NUM_PORTS, or with pending[t]==0 and discard[t]==0: dropped.
//    Sets sticky internal error bit (sim assertion).
//  - o_port_data/o_port_aux hold last value when no ack (OPT_LOWPOWER-style zeroing not applied).
//  - Reset mid-operation clears all counters; late controller acks are then dropped as stray.
// TESTING
//  - Single port 0, 4 back-to-back reads, controller acks aux={0,x} -> o_port_ack=4'b0001 x4,
//    pending back to 0.
//  - Ports 0..3 all stb continuously, no stall -> grants 0,1,2,3,0,... and o_wb_aux tag
//    matches grant each cycle.
//  - Port 1 issues MAX_OUTSTANDING=16 reads, no acks -> 17th stalled, other ports still granted.
//  - Port 2: 3 requests in flight, cyc dropped, re-asserted next cycle -> stalled until 3 acks
//    with tag 2 arrive; none appear on o_port_ack.
//  - i_wb_stall=1 for 5 cycles with all ports requesting -> no accept, rr pointer and counters
//    unchanged.
//  - Reset asserted with 2 pending on port 0 -> o_wb_cyc=0 next cycle, subsequent ack tag 0
//    dropped, error bit set.

Source files
------------

// File: rtl/ddr3_wb_arbiter_if.sv
// ddr3_wb_arbiter_if
//   Bundles the upstream (per-port, packed) Wishbone signals, the downstream
//   controller Wishbone signals and the arbiter's debug outputs.
//   Handshake: a port request transfers on a cycle where cyc & stb are high
//   and o_port_stall is low. A downstream request transfers on a cycle where
//   o_wb_stb is high and i_wb_stall is low. Acks are single-cycle pulses that
//   qualify the data/aux returned alongside them.
//   Modports:
//     slave  - the arbiter: consumes i_* signals, drives o_* signals
//     master - the environment (masters + controller): the reverse
//   Debug: o_dbg_rr (round-robin pointer), o_dbg_error (sticky stray-ack flag).
interface ddr3_wb_arbiter_if #(
  parameter int NUM_PORTS      = 4,
  parameter int WB_ADDR_BITS   = 24,
  parameter int WB_DATA_BITS   = 512,
  parameter int PORT_AUX_WIDTH = 8
);
  localparam int TAG_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AUX_BITS = TAG_BITS + PORT_AUX_WIDTH;

  // upstream ports
  logic [NUM_PORTS-1:0]                    i_port_cyc;
  logic [NUM_PORTS-1:0]                    i_port_stb;
  logic [NUM_PORTS-1:0]                    i_port_we;
  logic [NUM_PORTS*WB_ADDR_BITS-1:0]       i_port_addr;
  logic [NUM_PORTS*WB_DATA_BITS-1:0]       i_port_data;
  logic [NUM_PORTS*WB_DATA_BITS/8-1:0]     i_port_sel;
  logic [NUM_PORTS*PORT_AUX_WIDTH-1:0]     i_port_aux;
  logic [NUM_PORTS-1:0]                    o_port_stall;
  logic [NUM_PORTS-1:0]                    o_port_ack;
  logic [WB_DATA_BITS-1:0]                 o_port_data;
  logic [PORT_AUX_WIDTH-1:0]               o_port_aux;

  // downstream controller bus
  logic                                    o_wb_cyc;
  logic                                    o_wb_stb;
  logic                                    o_wb_we;
  logic [WB_ADDR_BITS-1:0]                 o_wb_addr;
  logic [WB_DATA_BITS-1:0]                 o_wb_data;
  logic [WB_DATA_BITS/8-1:0]               o_wb_sel;
  logic [AUX_BITS-1:0]                     o_wb_aux;
  logic                                    i_wb_stall;
  logic                                    i_wb_ack;
  logic [WB_DATA_BITS-1:0]                 i_wb_data;
  logic [AUX_BITS-1:0]                     i_wb_aux;

  // debug
  logic [TAG_BITS-1:0]                     o_dbg_rr;
  logic                                    o_dbg_error;

  modport slave (
    input  i_port_cyc, i_port_stb, i_port_we, i_port_addr, i_port_data,
           i_port_sel, i_port_aux, i_wb_stall, i_wb_ack, i_wb_data, i_wb_aux,
    output o_port_stall, o_port_ack, o_port_data, o_port_aux,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_wb_aux,
           o_dbg_rr, o_dbg_error
  );

  modport master (
    output i_port_cyc, i_port_stb, i_port_we, i_port_addr, i_port_data,
           i_port_sel, i_port_aux, i_wb_stall, i_wb_ack, i_wb_data, i_wb_aux,
    input  o_port_stall, o_port_ack, o_port_data, o_port_aux,
           o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_wb_aux,
           o_dbg_rr, o_dbg_error
  );
endinterface

// File: rtl/ddr3_wb_arbiter.sv
// ddr3_wb_arbiter
//   N-port pipelined Wishbone front end for the DDR3 controller user port.
//   Round-robin arbitrates the ports onto one downstream stream with zero added
//   request latency, tags each request with its port index in the upper aux
//   bits, and routes each returned ack/data/aux (one registered cycle later) to
//   the tagged port. A port that drops cyc with requests in flight has those
//   requests converted to "discards": their acks are swallowed and the port
//   stays stalled until all of them have returned, while the downstream cyc
//   stays up.
//   Ports:
//     i_controller_clk - clock
//     i_rst            - synchronous active-high reset
//     bus              - ddr3_wb_arbiter_if.slave (upstream, downstream, debug)
module ddr3_wb_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int WB_ADDR_BITS    = 24,
  parameter int WB_DATA_BITS    = 512,
  parameter int PORT_AUX_WIDTH  = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic             i_controller_clk,
  input  logic             i_rst,
  ddr3_wb_arbiter_if.slave bus
);
  localparam int TAG_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SEL_BITS = WB_DATA_BITS / 8;
  localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_BITS:0]   NUM_PORTS_W = (TAG_BITS + 1)'(NUM_PORTS);
  localparam logic [TAG_BITS-1:0] LAST_PORT   = TAG_BITS'(NUM_PORTS - 1);

  logic [TAG_BITS-1:0]       rr_ptr;
  logic [TAG_BITS-1:0]       grant;
  logic                      any_eligible;
  logic                      accept;
  logic [TAG_BITS:0]         cand;
  logic [NUM_PORTS-1:0]      eligible;
  logic [NUM_PORTS-1:0]      busy;
  logic [CNT_W-1:0]          pending     [NUM_PORTS];
  logic [CNT_W-1:0]          discard     [NUM_PORTS];
  logic [CNT_W-1:0]          pending_nxt [NUM_PORTS];
  logic [CNT_W-1:0]          discard_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0]      hit, take_pend, take_disc, deliver;
  logic                      stray;
  logic                      err_q;
  logic [TAG_BITS-1:0]       ack_tag;
  logic                      tag_ok;
  logic [NUM_PORTS-1:0]      port_ack_q;
  logic [WB_DATA_BITS-1:0]   port_data_q;
  logic [PORT_AUX_WIDTH-1:0] port_aux_q;

  logic                      req_we;
  logic [WB_ADDR_BITS-1:0]   req_addr;
  logic [WB_DATA_BITS-1:0]   req_data;
  logic [SEL_BITS-1:0]       req_sel;
  logic [PORT_AUX_WIDTH-1:0] req_aux;
  logic [NUM_PORTS-1:0]      stall;

  // A port is eligible only while it has no discards outstanding and is
  // below its in-flight cap.
  always_comb begin
    eligible = '0;
    busy     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = bus.i_port_cyc[p] & bus.i_port_stb[p] &
                    (discard[p] == '0) & (pending[p] < CNT_MAX);
      busy[p]     = (pending[p] != '0) | (discard[p] != '0);
    end
  end

  // First eligible port at or after the round-robin pointer, wrapping.
  always_comb begin
    grant        = '0;
    any_eligible = 1'b0;
    cand         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (TAG_BITS + 1)'(i);
      if (cand >= NUM_PORTS_W) cand = cand - NUM_PORTS_W;
      if (!any_eligible && eligible[cand[TAG_BITS-1:0]]) begin
        any_eligible = 1'b1;
        grant        = cand[TAG_BITS-1:0];
      end
    end
  end

  // Request field mux and per-port stall.
  always_comb begin
    req_we   = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_sel  = '0;
    req_aux  = '0;
    stall    = '1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant == TAG_BITS'(p)) begin
        req_we   = bus.i_port_we[p];
        req_addr = bus.i_port_addr[p*WB_ADDR_BITS +: WB_ADDR_BITS];
        req_data = bus.i_port_data[p*WB_DATA_BITS +: WB_DATA_BITS];
        req_sel  = bus.i_port_sel[p*SEL_BITS +: SEL_BITS];
        req_aux  = bus.i_port_aux[p*PORT_AUX_WIDTH +: PORT_AUX_WIDTH];
      end
      stall[p] = i_rst | bus.i_wb_stall | ~(any_eligible & (grant == TAG_BITS'(p)));
    end
  end

  assign bus.o_wb_stb     = ~i_rst & any_eligible;
  assign bus.o_wb_cyc     = ~i_rst & ((|bus.i_port_cyc) | (|busy));
  assign bus.o_wb_we      = req_we;
  assign bus.o_wb_addr    = req_addr;
  assign bus.o_wb_data    = req_data;
  assign bus.o_wb_sel     = req_sel;
  assign bus.o_wb_aux     = {grant, req_aux};
  assign bus.o_port_stall = stall;
  assign accept           = bus.o_wb_stb & ~bus.i_wb_stall;

  assign ack_tag = bus.i_wb_aux[TAG_BITS+PORT_AUX_WIDTH-1 -: TAG_BITS];
  assign tag_ok  = {1'b0, ack_tag} < NUM_PORTS_W;

  // Counter updates. pending and discard are never both non-zero for a port:
  // discards only arise from an abort (which empties pending) and a port with
  // discards cannot be granted.
  always_comb begin
    hit       = '0;
    take_pend = '0;
    take_disc = '0;
    deliver   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p]       = bus.i_wb_ack & tag_ok & (ack_tag == TAG_BITS'(p));
      take_disc[p] = hit[p] & (discard[p] != '0);
      take_pend[p] = hit[p] & (discard[p] == '0) & (pending[p] != '0);
      if (!bus.i_port_cyc[p] && (pending[p] != '0)) begin
        // Abort: everything still in flight (less an ack consumed now)
        // is owed to the controller and must be swallowed.
        pending_nxt[p] = '0;
        discard_nxt[p] = discard[p] + pending[p] -
                         {{(CNT_W-1){1'b0}}, take_pend[p] | take_disc[p]};
      end else begin
        pending_nxt[p] = pending[p] +
                         {{(CNT_W-1){1'b0}}, accept & (grant == TAG_BITS'(p))} -
                         {{(CNT_W-1){1'b0}}, take_pend[p]};
        discard_nxt[p] = discard[p] - {{(CNT_W-1){1'b0}}, take_disc[p]};
        deliver[p]     = take_pend[p];
      end
    end
    stray = bus.i_wb_ack & ~(|(take_pend | take_disc));
  end

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      rr_ptr     <= '0;
      port_ack_q <= '0;
      err_q      <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        pending[p] <= '0;
        discard[p] <= '0;
      end
    end else begin
      pending    <= pending_nxt;
      discard    <= discard_nxt;
      port_ack_q <= deliver;
      if (accept) rr_ptr <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
      if (|deliver) begin
        port_data_q <= bus.i_wb_data;
        port_aux_q  <= bus.i_wb_aux[PORT_AUX_WIDTH-1:0];
      end
      if (stray) err_q <= 1'b1;
    end
  end

  assign bus.o_port_ack  = port_ack_q;
  assign bus.o_port_data = port_data_q;
  assign bus.o_port_aux  = port_aux_q;
  assign bus.o_dbg_rr    = rr_ptr;
  assign bus.o_dbg_error = err_q;
endmodule
